// File: rtl/noc_params.sv
// -----------------------------------------------------------------------------
// noc_params
// Shared router parameters, flit/lock types and small helper functions for
// the output-port lock scheduler and its round-robin picker.
//   PORT_NUM  : router input ports (= output ports)
//   VC_NUM    : virtual channels per port
//   PORT_SIZE : bits needed for a port index
//   VC_SIZE   : bits needed for a VC index
// -----------------------------------------------------------------------------
package noc_params;

  localparam int PORT_NUM  = 5;
  localparam int VC_NUM    = 2;
  localparam int PORT_SIZE = $clog2(PORT_NUM);
  localparam int VC_SIZE   = $clog2(VC_NUM);

  typedef logic [PORT_SIZE-1:0] port_t;
  typedef logic [VC_SIZE-1:0]   vc_t;

  typedef enum logic [1:0] {
    HEAD     = 2'd0,
    BODY     = 2'd1,
    TAIL     = 2'd2,
    HEADTAIL = 2'd3
  } flit_label_t;

  typedef enum logic {
    FREE   = 1'b0,
    LOCKED = 1'b1
  } lock_state_t;

  // HEAD and HEADTAIL both open a packet and therefore compete in arbitration.
  function automatic logic isHeadLabel(input flit_label_t label);
    return (label == HEAD) || (label == HEADTAIL);
  endfunction

  // Port index plus one, wrapping back to port 0 after the last port.
  function automatic port_t nextPort(input port_t p);
    return (p == port_t'(PORT_NUM - 1)) ? '0 : p + port_t'(1);
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// -----------------------------------------------------------------------------
// rr_priority_picker
// Purely combinational round-robin picker: scans the request vector starting
// at the pointer position, wrapping mod PORT_NUM, and selects the first set
// request.
// Ports:
//   i_req   [PORT_NUM]  request per input port
//   i_ptr   port_t      highest-priority position this cycle
//   o_grant [PORT_NUM]  one-hot grant (all zero if nothing requested)
//   o_index port_t      index of the granted request
//   o_valid 1           some request was granted
// -----------------------------------------------------------------------------
module rr_priority_picker
  import noc_params::*;
(
  input  logic [PORT_NUM-1:0] i_req,
  input  port_t               i_ptr,
  output logic [PORT_NUM-1:0] o_grant,
  output port_t               o_index,
  output logic                o_valid
);

  logic [PORT_SIZE:0] w_pos;

  // Walk positions ptr, ptr+1, ... (mod PORT_NUM); the first hit wins and
  // later hits are ignored via o_valid.
  always_comb begin
    o_grant = '0;
    o_index = '0;
    o_valid = 1'b0;
    w_pos   = '0;
    for (int i = 0; i < PORT_NUM; i++) begin
      w_pos = {1'b0, i_ptr} + (PORT_SIZE + 1)'(i);
      if (w_pos >= (PORT_SIZE + 1)'(PORT_NUM)) begin
        w_pos = w_pos - (PORT_SIZE + 1)'(PORT_NUM);
      end
      if (!o_valid && i_req[w_pos[PORT_SIZE-1:0]]) begin
        o_valid                     = 1'b1;
        o_index                     = w_pos[PORT_SIZE-1:0];
        o_grant[w_pos[PORT_SIZE-1:0]] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/output_port_lock_scheduler.sv
// -----------------------------------------------------------------------------
// output_port_lock_scheduler
// Wormhole output-port scheduler. Each output arbitrates round-robin among
// HEAD/HEADTAIL flits while FREE; a winning HEAD locks the output to its input
// port and downstream VC until that input's TAIL is granted. Grants go back
// to the input blocks combinationally; crossbar/VC selects are registered for
// the switch-traversal stage.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   req_i                 input p presents a flit this cycle
//   req_out_port_i        target output of p's flit
//   req_flit_label_i      HEAD/BODY/TAIL/HEADTAIL
//   req_downstream_vc_i   downstream VC carried by HEAD/HEADTAIL
//   on_off_i              downstream ready per output/VC
//   grant_o               flit of input p accepted this cycle (comb)
//   valid_sel_o           output o carries a flit this cycle (reg)
//   crossbar_sel_o        input port driving output o (reg)
//   vc_sel_o              downstream VC for output o's flit (reg)
//   locked_o              output o is LOCKED (reg)
//   err_o                 sticky protocol-error flag per output (reg), present
//                         only when OUTPUT_LOCK_ERR_EN is defined
// Build option: OUTPUT_LOCK_ERR_EN
// -----------------------------------------------------------------------------
module output_port_lock_scheduler
  import noc_params::*;
(
  input  logic                            clk,
  input  logic                            rst,
  input  logic [PORT_NUM-1:0]             req_i,
  input  port_t [PORT_NUM-1:0]            req_out_port_i,
  input  flit_label_t [PORT_NUM-1:0]      req_flit_label_i,
  input  vc_t [PORT_NUM-1:0]              req_downstream_vc_i,
  input  logic [PORT_NUM-1:0][VC_NUM-1:0] on_off_i,
  output logic [PORT_NUM-1:0]             grant_o,
  output logic [PORT_NUM-1:0]             valid_sel_o,
  output port_t [PORT_NUM-1:0]            crossbar_sel_o,
  output vc_t [PORT_NUM-1:0]              vc_sel_o,
  output logic [PORT_NUM-1:0]             locked_o
`ifdef OUTPUT_LOCK_ERR_EN
  ,
  output logic [PORT_NUM-1:0]             err_o
`endif
);

  lock_state_t [PORT_NUM-1:0] r_state;
  port_t [PORT_NUM-1:0]       r_owner;
  vc_t [PORT_NUM-1:0]         r_ownerVc;
  port_t [PORT_NUM-1:0]       r_rrPtr;
  logic [PORT_NUM-1:0]        r_validSel;
  port_t [PORT_NUM-1:0]       r_crossbarSel;
  vc_t [PORT_NUM-1:0]         r_vcSel;

  logic [PORT_NUM-1:0][PORT_NUM-1:0] w_headReq;
  logic [PORT_NUM-1:0][PORT_NUM-1:0] w_pickGrant;
  logic [PORT_NUM-1:0][PORT_NUM-1:0] w_outGrant;
  port_t [PORT_NUM-1:0]              w_pickIdx;
  port_t [PORT_NUM-1:0]              w_winner;
  logic [PORT_NUM-1:0]               w_pickValid;
  logic [PORT_NUM-1:0]               w_ownerGo;
  logic [PORT_NUM-1:0]               w_outValid;

  // Per-output eligibility. A FREE output only sees heads whose chosen
  // downstream VC is ready; a LOCKED output only sees its owner's BODY/TAIL,
  // gated by the ready bit of the VC captured at lock time.
  always_comb begin
    w_headReq = '0;
    w_ownerGo = '0;
    for (int o = 0; o < PORT_NUM; o++) begin
      for (int p = 0; p < PORT_NUM; p++) begin
        if (req_i[p] && (req_out_port_i[p] == port_t'(o))) begin
          if (r_state[o] == FREE) begin
            if (isHeadLabel(req_flit_label_i[p])) begin
              w_headReq[o][p] = on_off_i[o][req_downstream_vc_i[p]];
            end
          end else if ((r_owner[o] == port_t'(p)) && !isHeadLabel(req_flit_label_i[p])) begin
            w_ownerGo[o] = on_off_i[o][r_ownerVc[o]];
          end
        end
      end
    end
  end

  for (genvar o = 0; o < PORT_NUM; o++) begin : g_pick
    rr_priority_picker u_pick (
      .i_req   (w_headReq[o]),
      .i_ptr   (r_rrPtr[o]),
      .o_grant (w_pickGrant[o]),
      .o_index (w_pickIdx[o]),
      .o_valid (w_pickValid[o])
    );
  end

  // Select the winner per output (picker when FREE, owner when LOCKED) and
  // fold the per-output grants into one grant per input. Each input targets
  // only one output, so the OR never merges two grants for the same input.
  always_comb begin
    w_outGrant = '0;
    w_winner   = '0;
    w_outValid = '0;
    grant_o    = '0;
    for (int o = 0; o < PORT_NUM; o++) begin
      if (r_state[o] == FREE) begin
        w_outGrant[o] = w_pickGrant[o];
        w_winner[o]   = w_pickIdx[o];
        w_outValid[o] = w_pickValid[o];
      end else begin
        w_outGrant[o][r_owner[o]] = w_ownerGo[o];
        w_winner[o]               = r_owner[o];
        w_outValid[o]             = w_ownerGo[o];
      end
      grant_o = grant_o | w_outGrant[o];
    end
  end

  // Lock FSM plus registered switch selects. Only head grants on a FREE
  // output advance the round-robin pointer; a HEADTAIL leaves the output
  // FREE. Selects hold their value on idle cycles, only valid drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int o = 0; o < PORT_NUM; o++) begin
        r_state[o]       <= FREE;
        r_owner[o]       <= '0;
        r_ownerVc[o]     <= '0;
        r_rrPtr[o]       <= '0;
        r_crossbarSel[o] <= '0;
        r_vcSel[o]       <= '0;
      end
      r_validSel <= '0;
    end else begin
      for (int o = 0; o < PORT_NUM; o++) begin
        r_validSel[o] <= w_outValid[o];
        if (w_outValid[o]) begin
          r_crossbarSel[o] <= w_winner[o];
          if (r_state[o] == FREE) begin
            r_vcSel[o] <= req_downstream_vc_i[w_winner[o]];
            r_rrPtr[o] <= nextPort(w_winner[o]);
            if (req_flit_label_i[w_winner[o]] == HEAD) begin
              r_state[o]   <= LOCKED;
              r_owner[o]   <= w_winner[o];
              r_ownerVc[o] <= req_downstream_vc_i[w_winner[o]];
            end
          end else begin
            r_vcSel[o] <= r_ownerVc[o];
            if (req_flit_label_i[w_winner[o]] == TAIL) begin
              r_state[o] <= FREE;
            end
          end
        end
      end
    end
  end

  // Output views of the registered state.
  always_comb begin
    for (int o = 0; o < PORT_NUM; o++) begin
      locked_o[o] = (r_state[o] == LOCKED);
    end
  end

  assign valid_sel_o    = r_validSel;
  assign crossbar_sel_o = r_crossbarSel;
  assign vc_sel_o       = r_vcSel;

`ifdef OUTPUT_LOCK_ERR_EN
  logic [PORT_NUM-1:0] w_protoErr;
  logic [PORT_NUM-1:0] r_err;

  // Protocol errors: a BODY/TAIL aimed at a FREE output, or a fresh head
  // from the input that already owns the LOCKED output.
  always_comb begin
    w_protoErr = '0;
    for (int o = 0; o < PORT_NUM; o++) begin
      for (int p = 0; p < PORT_NUM; p++) begin
        if (req_i[p] && (req_out_port_i[p] == port_t'(o))) begin
          if ((r_state[o] == FREE) && !isHeadLabel(req_flit_label_i[p])) begin
            w_protoErr[o] = 1'b1;
          end
          if ((r_state[o] == LOCKED) && (r_owner[o] == port_t'(p)) &&
              isHeadLabel(req_flit_label_i[p])) begin
            w_protoErr[o] = 1'b1;
          end
        end
      end
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= '0;
    end else begin
      r_err <= r_err | w_protoErr;
    end
  end

  assign err_o = r_err;
`endif

endmodule
